// File: rtl/l2_arbiter.sv
// L2 port arbiter between icache and dcache.
// Round-robin on ties, one-cycle release gap, sticky grant-timeout flag.
module l2_arbiter #(
    parameter logic [15:0] TIMEOUT = 16'd1023
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ic_drq,
    input  logic [31:0] ic_addr,
    input  logic [8:0]  ic_index,
    input  logic        dc_drq,
    input  logic [31:0] dc_addr,
    input  logic [8:0]  dc_index,
    input  logic        dc_rw,
    input  logic        l2_busy,
    input  logic        l2_rdy,
    input  logic        l2_complete,
    output logic        l2_drq,
    output logic [31:0] l2_addr,
    output logic [8:0]  l2_index,
    output logic        l2_cache_rw,
    output logic        owner,
    output logic        grant_vld,
    output logic        ic_l2_busy,
    output logic        dc_l2_busy,
    output logic        ic_l2_rdy,
    output logic        dc_l2_rdy,
    output logic        dc_l2_complete,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT_IC,
        GRANT_DC,
        RELEASE
    } state_t;

    state_t      state;
    state_t      state_nxt;
    logic        last;
    logic [15:0] cnt;
    logic [15:0] cnt_nxt;
    logic        err;
    logic        grant_nxt;

    assign grant_nxt = (state_nxt == GRANT_IC) || (state_nxt == GRANT_DC);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            last  <= 1'b0;
            cnt   <= 16'd0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (state == IDLE && state_nxt == GRANT_IC)
                last <= 1'b0;
            else if (state == IDLE && state_nxt == GRANT_DC)
                last <= 1'b1;
            if (grant_nxt && cnt_nxt == TIMEOUT)
                err <= 1'b1;
        end
    end

    // Counter holds the number of grant cycles seen so far, including the current one
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            IDLE: begin
                if (ic_drq && dc_drq)
                    state_nxt = last ? GRANT_IC : GRANT_DC;
                else if (ic_drq)
                    state_nxt = GRANT_IC;
                else if (dc_drq)
                    state_nxt = GRANT_DC;
                if (state_nxt != IDLE)
                    cnt_nxt = 16'd1;
            end
            GRANT_IC: begin
                if (!ic_drq)
                    state_nxt = RELEASE;
                else if (cnt != TIMEOUT)
                    cnt_nxt = cnt + 16'd1;
            end
            GRANT_DC: begin
                if (!dc_drq)
                    state_nxt = RELEASE;
                else if (cnt != TIMEOUT)
                    cnt_nxt = cnt + 16'd1;
            end
            RELEASE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        l2_drq         = 1'b0;
        l2_addr        = 32'd0;
        l2_index       = 9'd0;
        l2_cache_rw    = 1'b0;
        grant_vld      = 1'b0;
        ic_l2_busy     = 1'b1;
        dc_l2_busy     = 1'b1;
        ic_l2_rdy      = 1'b0;
        dc_l2_rdy      = 1'b0;
        dc_l2_complete = 1'b0;
        unique case (state)
            IDLE: begin
                ic_l2_busy = l2_busy;
                dc_l2_busy = l2_busy;
            end
            GRANT_IC: begin
                l2_drq     = ic_drq;
                l2_addr    = ic_addr;
                l2_index   = ic_index;
                grant_vld  = 1'b1;
                ic_l2_busy = l2_busy;
                ic_l2_rdy  = l2_rdy && !rst;
            end
            GRANT_DC: begin
                l2_drq         = dc_drq;
                l2_addr        = dc_addr;
                l2_index       = dc_index;
                l2_cache_rw    = dc_rw;
                grant_vld      = 1'b1;
                dc_l2_busy     = l2_busy;
                dc_l2_rdy      = l2_rdy && !rst;
                dc_l2_complete = l2_complete && !rst;
            end
            RELEASE: ;
            default: ;
        endcase
    end

    assign owner       = last;
    assign timeout_err = err;

endmodule

// File: tb/tb_l2_arbiter.sv
// Directed bench for l2_arbiter: ties, routing, dirty miss,
// timeout flag and mid-grant reset.
module tb_l2_arbiter;

    logic        clk;
    logic        rst;
    logic        ic_drq;
    logic [31:0] ic_addr;
    logic [8:0]  ic_index;
    logic        dc_drq;
    logic [31:0] dc_addr;
    logic [8:0]  dc_index;
    logic        dc_rw;
    logic        l2_busy;
    logic        l2_rdy;
    logic        l2_complete;
    logic        l2_drq;
    logic [31:0] l2_addr;
    logic [8:0]  l2_index;
    logic        l2_cache_rw;
    logic        owner;
    logic        grant_vld;
    logic        ic_l2_busy;
    logic        dc_l2_busy;
    logic        ic_l2_rdy;
    logic        dc_l2_rdy;
    logic        dc_l2_complete;
    logic        timeout_err;

    int n_chk;
    int n_pass;

    l2_arbiter #(.TIMEOUT(16'd8)) dut (
        .clk            (clk),
        .rst            (rst),
        .ic_drq         (ic_drq),
        .ic_addr        (ic_addr),
        .ic_index       (ic_index),
        .dc_drq         (dc_drq),
        .dc_addr        (dc_addr),
        .dc_index       (dc_index),
        .dc_rw          (dc_rw),
        .l2_busy        (l2_busy),
        .l2_rdy         (l2_rdy),
        .l2_complete    (l2_complete),
        .l2_drq         (l2_drq),
        .l2_addr        (l2_addr),
        .l2_index       (l2_index),
        .l2_cache_rw    (l2_cache_rw),
        .owner          (owner),
        .grant_vld      (grant_vld),
        .ic_l2_busy     (ic_l2_busy),
        .dc_l2_busy     (dc_l2_busy),
        .ic_l2_rdy      (ic_l2_rdy),
        .dc_l2_rdy      (dc_l2_rdy),
        .dc_l2_complete (dc_l2_complete),
        .timeout_err    (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk       = 0;
        n_pass      = 0;
        rst         = 1'b1;
        ic_drq      = 1'b0;
        ic_addr     = 32'h1111_0000;
        ic_index    = 9'h011;
        dc_drq      = 1'b0;
        dc_addr     = 32'hD000_0040;
        dc_index    = 9'h0D4;
        dc_rw       = 1'b0;
        l2_busy     = 1'b1;
        l2_rdy      = 1'b0;
        l2_complete = 1'b0;
        tick();
        tick();
        #1;
        chk("rst_drq", l2_drq, 0);
        chk("rst_gv", grant_vld, 0);
        chk("rst_own", owner, 0);
        chk("rst_err", timeout_err, 0);
        chk("rst_addr", l2_addr, 0);
        chk("rst_icb", ic_l2_busy, 1);
        l2_busy = 1'b0;
        #1;
        chk("rst_dcb", dc_l2_busy, 0);
        rst = 1'b0;

        // first tie goes to dcache
        ic_drq = 1'b1;
        dc_drq = 1'b1;
        tick();
        #1;
        chk("tie1_gv", grant_vld, 1);
        chk("tie1_drq", l2_drq, 1);
        chk("tie1_own", owner, 1);
        chk("tie1_addr", l2_addr, 32'hD000_0040);
        chk("tie1_idx", l2_index, 9'h0D4);
        chk("tie1_icb", ic_l2_busy, 1);
        chk("tie1_dcb", dc_l2_busy, 0);
        l2_rdy = 1'b1;
        #1;
        chk("tie1_dcr", dc_l2_rdy, 1);
        chk("tie1_icr", ic_l2_rdy, 0);
        tick();
        l2_rdy = 1'b0;
        dc_drq = 1'b0;
        #1;
        chk("drop_drq", l2_drq, 0);
        tick();
        dc_drq = 1'b1;
        #1;
        chk("rel_gv", grant_vld, 0);
        chk("rel_icb", ic_l2_busy, 1);
        chk("rel_dcb", dc_l2_busy, 1);
        chk("rel_addr", l2_addr, 0);
        tick();
        #1;
        chk("idle_gv", grant_vld, 0);
        chk("idle_own", owner, 1);
        tick();
        dc_rw       = 1'b1;
        l2_rdy      = 1'b1;
        l2_complete = 1'b1;
        #1;
        chk("tie2_own", owner, 0);
        chk("tie2_gv", grant_vld, 1);
        chk("tie2_addr", l2_addr, 32'h1111_0000);
        chk("tie2_idx", l2_index, 9'h011);
        chk("ic_rw", l2_cache_rw, 0);
        chk("ic_rdy", ic_l2_rdy, 1);
        chk("ic_dcr", dc_l2_rdy, 0);
        chk("ic_dcc", dc_l2_complete, 0);
        chk("ic_dcb", dc_l2_busy, 1);
        tick();
        l2_rdy      = 1'b0;
        l2_complete = 1'b0;
        ic_drq      = 1'b0;
        tick();
        ic_drq = 1'b1;
        tick();
        tick();
        #1;
        chk("tie3_own", owner, 1);
        chk("tie3_gv", grant_vld, 1);

        // dirty miss: write-back then refill under one grant
        dc_addr = 32'hA000_0100;
        #1;
        chk("wb_rw", l2_cache_rw, 1);
        chk("wb_addr", l2_addr, 32'hA000_0100);
        l2_complete = 1'b1;
        #1;
        chk("wb_cmp", dc_l2_complete, 1);
        tick();
        l2_complete = 1'b0;
        dc_rw       = 1'b0;
        dc_addr     = 32'hB000_0200;
        #1;
        chk("rf_cmp", dc_l2_complete, 0);
        chk("rf_rw", l2_cache_rw, 0);
        chk("rf_addr", l2_addr, 32'hB000_0200);
        chk("rf_gv", grant_vld, 1);
        l2_rdy = 1'b1;
        #1;
        chk("rf_rdy", dc_l2_rdy, 1);
        tick();
        l2_rdy = 1'b0;
        #1;
        chk("rf_rdy0", dc_l2_rdy, 0);
        chk("rf_own", owner, 1);
        dc_drq = 1'b0;
        ic_drq = 1'b0;
        tick();
        tick();
        l2_rdy = 1'b1;
        #1;
        chk("idle_icr", ic_l2_rdy, 0);
        chk("idle_dcr", dc_l2_rdy, 0);
        l2_rdy = 1'b0;

        // grant timeout at 8th cycle, sticky
        ic_drq = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            #1;
            chk($sformatf("to_c%0d", k), timeout_err, (k >= 8) ? 1 : 0);
            chk($sformatf("to_gv%0d", k), grant_vld, 1);
            if (k == 20)
                ic_drq = 1'b0;
        end
        tick();
        #1;
        chk("to_rel", timeout_err, 1);
        tick();
        #1;
        chk("to_idle", timeout_err, 1);

        // reset during dcache grant
        dc_drq = 1'b1;
        tick();
        #1;
        chk("rg_gv", grant_vld, 1);
        chk("rg_err", timeout_err, 1);
        rst    = 1'b1;
        l2_rdy = 1'b1;
        tick();
        #1;
        chk("rr_drq", l2_drq, 0);
        chk("rr_gv", grant_vld, 0);
        chk("rr_err", timeout_err, 0);
        chk("rr_dcr", dc_l2_rdy, 0);
        l2_rdy = 1'b0;
        rst    = 1'b0;
        tick();
        #1;
        chk("ra_gv", grant_vld, 1);
        chk("ra_own", owner, 1);
        chk("ra_drq", l2_drq, 1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
